t_ff_count_ctrl: RTL and testbench

Sequencing controller for a bank of T flip-flops forming a WIDTH-bit synchronous counter. Each cycle it computes the per-bit toggle vector that drives the flop bank (up or down, with wrap or one-shot termination) and holds that bank internally as the count register. It runs a start/pause/abort/done handshake so a host FSM can launch timed count sequences. This is the next layer above the standalone T flip-flop: it decides when and which flops toggle.

---
 rtl/t_ff_count_ctrl.sv | 151 +++++++++++++++
 tb/tb_t_ff_count_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/t_ff_count_ctrl.sv
// t_ff_count_ctrl: sequencing controller for a WIDTH-bit bank of T flip-flops.
// The bank is updated only in toggle form (count <= count ^ t_vec). Reloads
// are expressed as the toggle pattern count ^ target. A start/pause/abort/done
// handshake lets a host FSM launch up/down, one-shot or wrapping sequences.
module t_ff_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             dir,
    input  logic             wrap,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] t_vec,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] limit_r;
    logic             dir_r;
    logic             wrap_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] t_vec_s;
    logic [WIDTH-1:0] up_step_s;
    logic [WIDTH-1:0] dn_step_s;
    logic [WIDTH-1:0] start_live_s;
    logic [WIDTH-1:0] start_lat_s;
    logic [WIDTH-1:0] end_lat_s;
    logic             up_carry_s;
    logic             dn_borrow_s;

    // Sequence endpoints: live start value for the launch cycle, latched ones while running
    always_comb begin
        start_live_s = dir   ? {WIDTH{1'b0}} : limit;
        start_lat_s  = dir_r ? {WIDTH{1'b0}} : limit_r;
        end_lat_s    = dir_r ? limit_r       : {WIDTH{1'b0}};
    end

    // Ripple toggle enables: bit i flips when all lower bits are 1 (up) or all 0 (down)
    always_comb begin
        up_step_s   = {WIDTH{1'b0}};
        dn_step_s   = {WIDTH{1'b0}};
        up_carry_s  = 1'b1;
        dn_borrow_s = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_step_s[i] = up_carry_s;
            dn_step_s[i] = dn_borrow_s;
            up_carry_s   = up_carry_s & count_r[i];
            dn_borrow_s  = dn_borrow_s & ~count_r[i];
        end
    end

    // Toggle vector and next state; reset forces a quiet bank with no clock needed
    always_comb begin
        t_vec_s     = {WIDTH{1'b0}};
        state_nxt_s = state_r;
        if (!reset) begin
            t_vec_s     = {WIDTH{1'b0}};
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        t_vec_s     = count_r ^ start_live_s;
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_nxt_s = ST_IDLE;
                    end else if (pause) begin
                        state_nxt_s = ST_HOLD;
                    end else if (count_r == end_lat_s) begin
                        if (wrap_r) begin
                            t_vec_s     = count_r ^ start_lat_s;
                            state_nxt_s = ST_RUN;
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
                    end else begin
                        t_vec_s     = dir_r ? up_step_s : dn_step_s;
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        state_nxt_s = ST_IDLE;
                    end else if (!pause) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Controller FSM: T-flop bank, sequence parameters and registered status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            count_r <= {WIDTH{1'b0}};
            limit_r <= {WIDTH{1'b0}};
            dir_r   <= 1'b0;
            wrap_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            count_r <= count_r ^ t_vec_s;
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
            if ((state_r == ST_IDLE) && start) begin
                limit_r <= limit;
                dir_r   <= dir;
                wrap_r  <= wrap;
            end
        end
    end

    assign count = count_r;
    assign t_vec = t_vec_s;
    assign busy  = busy_r;
    assign done  = done_r;
    assign state = state_r;

endmodule

// File: tb/tb_t_ff_count_ctrl.sv
// Directed bench for t_ff_count_ctrl (WIDTH=4) with hand-computed expectations.
module tb_t_ff_count_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       pause;
    logic       abort;
    logic       dir;
    logic       wrap;
    logic [3:0] limit;
    logic [3:0] count;
    logic [3:0] t_vec;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int n_vec;
    int n_bad;

    t_ff_count_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .pause (pause),
        .abort (abort),
        .dir   (dir),
        .wrap  (wrap),
        .limit (limit),
        .count (count),
        .t_vec (t_vec),
        .busy  (busy),
        .done  (done),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0; start = 1'b1; dir = 1'b1; wrap = 1'b0;
        limit = 4'd5; pause = 1'b0; abort = 1'b0;

        // reset state, even with start held high
        #2;
        check_vec("rst_count", {4'd0, count}, 8'd0);
        check_vec("rst_state", {6'd0, state}, 8'd0);
        check_vec("rst_busy",  {7'd0, busy},  8'd0);
        check_vec("rst_done",  {7'd0, done},  8'd0);
        check_vec("rst_tvec",  {4'd0, t_vec}, 8'd0);
        tick();
        check_vec("rst_hold_state", {6'd0, state}, 8'd0);
        reset = 1'b1;

        // up one-shot, limit 5
        check_vec("up_launch_tvec", {4'd0, t_vec}, 8'd0);
        tick();
        check_vec("up_e0_count", {4'd0, count}, 8'd0);
        check_vec("up_e0_state", {6'd0, state}, 8'd1);
        check_vec("up_e0_busy",  {7'd0, busy},  8'd1);
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_vec("up_count", {4'd0, count}, 8'(i));
            if (i == 3) check_vec("up_tvec_at3", {4'd0, t_vec}, 8'h07);
            check_vec("up_no_done", {7'd0, done}, 8'd0);
        end
        tick();
        check_vec("up_e6_state", {6'd0, state}, 8'd3);
        check_vec("up_e6_done",  {7'd0, done},  8'd1);
        check_vec("up_e6_busy",  {7'd0, busy},  8'd1);
        check_vec("up_e6_count", {4'd0, count}, 8'd5);
        tick();
        check_vec("up_e7_state", {6'd0, state}, 8'd0);
        check_vec("up_e7_busy",  {7'd0, busy},  8'd0);
        check_vec("up_e7_done",  {7'd0, done},  8'd0);

        // down wrap, limit 3 (count currently 5)
        start = 1'b1; dir = 1'b0; wrap = 1'b1; limit = 4'd3;
        #1;
        check_vec("dn_launch_tvec", {4'd0, t_vec}, 8'h06);
        tick();
        check_vec("dn_e0_count", {4'd0, count}, 8'd3);
        start = 1'b0; limit = 4'd9; dir = 1'b1; wrap = 1'b0;
        tick(); check_vec("dn_c2", {4'd0, count}, 8'd2);
        tick(); check_vec("dn_c1", {4'd0, count}, 8'd1);
        tick(); check_vec("dn_c0", {4'd0, count}, 8'd0);
        check_vec("dn_reload_tvec", {4'd0, t_vec}, 8'h03);
        tick(); check_vec("dn_wrap3", {4'd0, count}, 8'd3);
        check_vec("dn_wrap_state", {6'd0, state}, 8'd1);
        check_vec("dn_no_done", {7'd0, done}, 8'd0);
        tick(); check_vec("dn_c2b", {4'd0, count}, 8'd2);
        abort = 1'b1;
        tick();
        check_vec("dn_abort_state", {6'd0, state}, 8'd0);
        check_vec("dn_abort_count", {4'd0, count}, 8'd2);
        check_vec("dn_abort_done",  {7'd0, done},  8'd0);
        abort = 1'b0;

        // pause mid-run, up limit 15
        start = 1'b1; dir = 1'b1; wrap = 1'b0; limit = 4'd15;
        #1;
        check_vec("ps_launch_tvec", {4'd0, t_vec}, 8'h02);
        tick();
        check_vec("ps_e0_count", {4'd0, count}, 8'd0);
        start = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        check_vec("ps_c7", {4'd0, count}, 8'd7);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("ps_hold_state", {6'd0, state}, 8'd2);
            check_vec("ps_hold_count", {4'd0, count}, 8'd7);
        end
        pause = 1'b0;
        tick();
        check_vec("ps_resume_state", {6'd0, state}, 8'd1);
        check_vec("ps_resume_count", {4'd0, count}, 8'd7);
        tick(); check_vec("ps_c8", {4'd0, count}, 8'd8);
        tick(); check_vec("ps_c9", {4'd0, count}, 8'd9);

        // abort and pause together: abort wins
        abort = 1'b1; pause = 1'b1;
        tick();
        check_vec("ab_state", {6'd0, state}, 8'd0);
        check_vec("ab_count", {4'd0, count}, 8'd9);
        check_vec("ab_done",  {7'd0, done},  8'd0);
        check_vec("ab_busy",  {7'd0, busy},  8'd0);
        abort = 1'b0; pause = 1'b0;

        // limit 0 up one-shot
        start = 1'b1; dir = 1'b1; wrap = 1'b0; limit = 4'd0;
        #1;
        check_vec("l0_reload_tvec", {4'd0, t_vec}, 8'h09);
        tick();
        check_vec("l0_e0_count", {4'd0, count}, 8'd0);
        check_vec("l0_e0_state", {6'd0, state}, 8'd1);
        start = 1'b0;
        tick();
        check_vec("l0_e1_state", {6'd0, state}, 8'd3);
        check_vec("l0_e1_done",  {7'd0, done},  8'd1);
        tick();
        check_vec("l0_e2_state", {6'd0, state}, 8'd0);

        // start during RUN ignored; limit/dir change after start has no effect
        start = 1'b1; dir = 1'b1; wrap = 1'b0; limit = 4'd4;
        tick();
        check_vec("lc_e0_count", {4'd0, count}, 8'd0);
        limit = 4'd2; dir = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_vec("lc_count", {4'd0, count}, 8'(i));
            check_vec("lc_state", {6'd0, state}, 8'd1);
        end
        start = 1'b0;
        tick();
        check_vec("lc_done_state", {6'd0, state}, 8'd3);
        check_vec("lc_done", {7'd0, done}, 8'd1);
        tick();
        check_vec("lc_idle", {6'd0, state}, 8'd0);

        // asynchronous reset mid-run at count 6
        start = 1'b1; dir = 1'b1; wrap = 1'b0; limit = 4'd15;
        tick();
        check_vec("ar_e0_count", {4'd0, count}, 8'd0);
        start = 1'b0;
        for (int i = 1; i <= 6; i++) tick();
        check_vec("ar_c6", {4'd0, count}, 8'd6);
        #3;
        reset = 1'b0;
        #1;
        check_vec("ar_count", {4'd0, count}, 8'd0);
        check_vec("ar_state", {6'd0, state}, 8'd0);
        check_vec("ar_busy",  {7'd0, busy},  8'd0);
        check_vec("ar_tvec",  {4'd0, t_vec}, 8'd0);
        reset = 1'b1;
        tick();
        check_vec("ar_post_state", {6'd0, state}, 8'd0);
        check_vec("ar_post_count", {4'd0, count}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
